// File: rtl/axi4_rr_arbiter_pkg.sv
// Shared types and constants for the two-master AXI4-lite round-robin arbiter.
// The watchdog option is compiled in with AXI4_ARB_WDT_EN.
package axi4_rr_arbiter_pkg;

  localparam int MIDX_W = 1;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  localparam logic [31:0] WDT_ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/axi4_rr_arbiter_grant.sv
// Two-way round-robin grant. idx_o is the last-granted master, which is also
// the owner of the path while a transaction is in flight.
module axi4_rr_arbiter_grant
  import axi4_rr_arbiter_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        req_i,
  input  logic              en_i,
  output logic              gnt_o,
  output logic [MIDX_W-1:0] idx_o
);

  logic [MIDX_W-1:0] last_q;
  logic [MIDX_W-1:0] pick;

  always_comb begin
    pick = last_q;
    case (req_i)
      2'b01:   pick = '0;
      2'b10:   pick = MIDX_W'(1);
      2'b11:   pick = ~last_q;
      default: pick = last_q;
    endcase
  end

  assign gnt_o = en_i && (|req_i);
  assign idx_o = last_q;

  // Pointer resets to master 1 so master 0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= MIDX_W'(1);
    end else if (gnt_o) begin
      last_q <= pick;
    end
  end

endmodule

// File: rtl/axi4_rr_arbiter.sv
// Two-master to one-slave AXI4-lite arbiter with independent round-robin read
// and write paths. Optional watchdog abort is enabled by AXI4_ARB_WDT_EN.
module axi4_rr_arbiter
  import axi4_rr_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WDT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                axi_s0_awvalid,
  input  logic [ADDR_W-1:0]   axi_s0_awaddr,
  input  logic [2:0]          axi_s0_awprot,
  output logic                axi_s0_awready,
  input  logic                axi_s0_wvalid,
  input  logic [DATA_W-1:0]   axi_s0_wdata,
  input  logic [DATA_W/8-1:0] axi_s0_wstrb,
  output logic                axi_s0_wready,
  output logic                axi_s0_bvalid,
  input  logic                axi_s0_bready,
  input  logic                axi_s0_arvalid,
  input  logic [ADDR_W-1:0]   axi_s0_araddr,
  input  logic [2:0]          axi_s0_arprot,
  output logic                axi_s0_arready,
  output logic                axi_s0_rvalid,
  output logic [DATA_W-1:0]   axi_s0_rdata,
  input  logic                axi_s0_rready,
  input  logic                axi_s1_awvalid,
  input  logic [ADDR_W-1:0]   axi_s1_awaddr,
  input  logic [2:0]          axi_s1_awprot,
  output logic                axi_s1_awready,
  input  logic                axi_s1_wvalid,
  input  logic [DATA_W-1:0]   axi_s1_wdata,
  input  logic [DATA_W/8-1:0] axi_s1_wstrb,
  output logic                axi_s1_wready,
  output logic                axi_s1_bvalid,
  input  logic                axi_s1_bready,
  input  logic                axi_s1_arvalid,
  input  logic [ADDR_W-1:0]   axi_s1_araddr,
  input  logic [2:0]          axi_s1_arprot,
  output logic                axi_s1_arready,
  output logic                axi_s1_rvalid,
  output logic [DATA_W-1:0]   axi_s1_rdata,
  input  logic                axi_s1_rready,
  output logic                axi_m_awvalid,
  output logic [ADDR_W-1:0]   axi_m_awaddr,
  output logic [2:0]          axi_m_awprot,
  input  logic                axi_m_awready,
  output logic                axi_m_wvalid,
  output logic [DATA_W-1:0]   axi_m_wdata,
  output logic [DATA_W/8-1:0] axi_m_wstrb,
  input  logic                axi_m_wready,
  input  logic                axi_m_bvalid,
  output logic                axi_m_bready,
  output logic                axi_m_arvalid,
  output logic [ADDR_W-1:0]   axi_m_araddr,
  output logic [2:0]          axi_m_arprot,
  input  logic                axi_m_arready,
  input  logic                axi_m_rvalid,
  input  logic [DATA_W-1:0]   axi_m_rdata,
  output logic                axi_m_rready,
  output logic                wdt_err
);

  if (WDT_CYCLES < 1) begin : g_wdt_cfg_err
    $error("WDT_CYCLES must be at least 1");
  end

  wr_state_e         w_state_q;
  rd_state_e         r_state_q;
  logic              aw_done_q, w_done_q;
  logic [MIDX_W-1:0] w_idx, r_idx;
  logic              w_gnt, r_gnt;
  logic              w_hit, w_abort, w_drain;
  logic              r_hit, r_abort, r_drain;

  logic              sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
  logic              w_in_addr, r_in_addr;
  logic              aw_hs, w_hs, ar_hs;
  logic              aw_ok, w_ok;
  logic              awready_g, wready_g, bvalid_g, arready_g, rvalid_g;
  logic [DATA_W-1:0] rdata_g;

  axi4_rr_arbiter_grant u_w_grant (
    .clk_i (clk),
    .rst_i (reset),
    .req_i ({axi_s1_awvalid | axi_s1_wvalid, axi_s0_awvalid | axi_s0_wvalid}),
    .en_i  ((w_state_q == W_IDLE) && !w_abort),
    .gnt_o (w_gnt),
    .idx_o (w_idx)
  );

  axi4_rr_arbiter_grant u_r_grant (
    .clk_i (clk),
    .rst_i (reset),
    .req_i ({axi_s1_arvalid, axi_s0_arvalid}),
    .en_i  ((r_state_q == R_IDLE) && !r_abort),
    .gnt_o (r_gnt),
    .idx_o (r_idx)
  );

  // Write path: owner's aw/w channels go straight through to the slave.
  assign sel_awvalid  = w_idx[0] ? axi_s1_awvalid : axi_s0_awvalid;
  assign sel_wvalid   = w_idx[0] ? axi_s1_wvalid  : axi_s0_wvalid;
  assign sel_bready   = w_idx[0] ? axi_s1_bready  : axi_s0_bready;
  assign axi_m_awaddr = w_idx[0] ? axi_s1_awaddr  : axi_s0_awaddr;
  assign axi_m_awprot = w_idx[0] ? axi_s1_awprot  : axi_s0_awprot;
  assign axi_m_wdata  = w_idx[0] ? axi_s1_wdata   : axi_s0_wdata;
  assign axi_m_wstrb  = w_idx[0] ? axi_s1_wstrb   : axi_s0_wstrb;

  assign w_in_addr     = (w_state_q == W_ADDR) && !w_hit;
  assign axi_m_awvalid = w_in_addr && sel_awvalid && !aw_done_q;
  assign axi_m_wvalid  = w_in_addr && sel_wvalid && !w_done_q;
  assign aw_hs         = axi_m_awvalid && axi_m_awready;
  assign w_hs          = axi_m_wvalid && axi_m_wready;
  assign aw_ok         = aw_done_q || aw_hs;
  assign w_ok          = w_done_q || w_hs;
  assign awready_g     = w_in_addr && !aw_done_q && axi_m_awready;
  assign wready_g      = w_in_addr && !w_done_q && axi_m_wready;
  assign bvalid_g      = ((w_state_q == W_RESP) && axi_m_bvalid && !w_hit) || w_hit || w_abort;
  assign axi_m_bready  = ((w_state_q == W_RESP) && sel_bready && !w_hit) || w_drain;

  assign axi_s0_awready = awready_g && !w_idx[0];
  assign axi_s1_awready = awready_g &&  w_idx[0];
  assign axi_s0_wready  = wready_g  && !w_idx[0];
  assign axi_s1_wready  = wready_g  &&  w_idx[0];
  assign axi_s0_bvalid  = bvalid_g  && !w_idx[0];
  assign axi_s1_bvalid  = bvalid_g  &&  w_idx[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          if (w_gnt) w_state_q <= W_ADDR;
        end
        W_ADDR: begin
          if (w_hit) begin
            w_state_q <= W_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else if (aw_ok && w_ok) begin
            w_state_q <= W_RESP;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            aw_done_q <= aw_ok;
            w_done_q  <= w_ok;
          end
        end
        W_RESP: begin
          if (w_hit || (axi_m_bvalid && sel_bready)) w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Read path: same shape, single address handshake then data pass-through.
  assign sel_arvalid  = r_idx[0] ? axi_s1_arvalid : axi_s0_arvalid;
  assign sel_rready   = r_idx[0] ? axi_s1_rready  : axi_s0_rready;
  assign axi_m_araddr = r_idx[0] ? axi_s1_araddr  : axi_s0_araddr;
  assign axi_m_arprot = r_idx[0] ? axi_s1_arprot  : axi_s0_arprot;

  assign r_in_addr     = (r_state_q == R_ADDR) && !r_hit;
  assign axi_m_arvalid = r_in_addr && sel_arvalid;
  assign ar_hs         = axi_m_arvalid && axi_m_arready;
  assign arready_g     = r_in_addr && axi_m_arready;
  assign rvalid_g      = ((r_state_q == R_DATA) && axi_m_rvalid && !r_hit) || r_hit || r_abort;
  assign rdata_g       = (r_hit || r_abort) ? DATA_W'(WDT_ABORT_DATA) : axi_m_rdata;
  assign axi_m_rready  = ((r_state_q == R_DATA) && sel_rready && !r_hit) || r_drain;

  assign axi_s0_arready = arready_g && !r_idx[0];
  assign axi_s1_arready = arready_g &&  r_idx[0];
  assign axi_s0_rvalid  = rvalid_g  && !r_idx[0];
  assign axi_s1_rvalid  = rvalid_g  &&  r_idx[0];
  assign axi_s0_rdata   = r_idx[0] ? '0 : rdata_g;
  assign axi_s1_rdata   = r_idx[0] ? rdata_g : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state_q <= R_IDLE;
    end else begin
      case (r_state_q)
        R_IDLE: if (r_gnt) r_state_q <= R_ADDR;
        R_ADDR: begin
          if (r_hit) r_state_q <= R_IDLE;
          else if (ar_hs) r_state_q <= R_DATA;
        end
        R_DATA: begin
          if (r_hit || (axi_m_rvalid && sel_rready)) r_state_q <= R_IDLE;
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

`ifdef AXI4_ARB_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);

  logic [WDT_W-1:0] w_cnt_q, r_cnt_q;
  logic             w_abort_q, w_drain_q, r_abort_q, r_drain_q, wdt_err_q;

  assign w_hit   = (w_state_q != W_IDLE) && (w_cnt_q == WDT_W'(WDT_CYCLES));
  assign r_hit   = (r_state_q != R_IDLE) && (r_cnt_q == WDT_W'(WDT_CYCLES));
  assign w_abort = w_abort_q;
  assign w_drain = w_drain_q;
  assign r_abort = r_abort_q;
  assign r_drain = r_drain_q;
  assign wdt_err = wdt_err_q;

  // On expiry the owner gets a synthesized response held until accepted; any
  // late slave response is swallowed until the path is granted again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_cnt_q   <= '0;
      r_cnt_q   <= '0;
      w_abort_q <= 1'b0;
      w_drain_q <= 1'b0;
      r_abort_q <= 1'b0;
      r_drain_q <= 1'b0;
      wdt_err_q <= 1'b0;
    end else begin
      if (w_gnt) begin
        w_cnt_q   <= '0;
        w_drain_q <= 1'b0;
      end else if ((w_state_q != W_IDLE) && !w_hit) begin
        w_cnt_q <= w_cnt_q + 1'b1;
      end
      if (w_hit) begin
        w_abort_q <= !sel_bready;
        w_drain_q <= 1'b1;
      end else if (w_abort_q && sel_bready) begin
        w_abort_q <= 1'b0;
      end

      if (r_gnt) begin
        r_cnt_q   <= '0;
        r_drain_q <= 1'b0;
      end else if ((r_state_q != R_IDLE) && !r_hit) begin
        r_cnt_q <= r_cnt_q + 1'b1;
      end
      if (r_hit) begin
        r_abort_q <= !sel_rready;
        r_drain_q <= 1'b1;
      end else if (r_abort_q && sel_rready) begin
        r_abort_q <= 1'b0;
      end

      if (w_hit || r_hit) wdt_err_q <= 1'b1;
    end
  end
`else
  assign w_hit   = 1'b0;
  assign r_hit   = 1'b0;
  assign w_abort = 1'b0;
  assign w_drain = 1'b0;
  assign r_abort = 1'b0;
  assign r_drain = 1'b0;
  assign wdt_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_rr_arbiter.sv
// Directed bench for axi4_rr_arbiter; the watchdog sequence runs only when
// AXI4_ARB_WDT_EN is defined.
module tb_axi4_rr_arbiter;

`ifdef AXI4_ARB_WDT_EN
  localparam int WDT = 16;
`else
  localparam int WDT = 255;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [1:0][31:0] s_awaddr, s_wdata, s_araddr;
  logic [1:0][3:0]  s_wstrb;
  logic [1:0]       s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0][31:0] s_rdata;

  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [31:0] m_awaddr, m_wdata, m_araddr;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        aw_rdy, w_rdy, ar_rdy;
  logic        sl_bvalid, sl_rvalid;
  logic [31:0] sl_rdata, rd_data;
  logic        wdt_err;

  axi4_rr_arbiter #(.ADDR_W(32), .DATA_W(32), .WDT_CYCLES(WDT)) dut (
    .clk(clk), .reset(reset),
    .axi_s0_awvalid(s_awvalid[0]), .axi_s0_awaddr(s_awaddr[0]), .axi_s0_awprot(3'd0),
    .axi_s0_awready(s_awready[0]), .axi_s0_wvalid(s_wvalid[0]), .axi_s0_wdata(s_wdata[0]),
    .axi_s0_wstrb(s_wstrb[0]), .axi_s0_wready(s_wready[0]), .axi_s0_bvalid(s_bvalid[0]),
    .axi_s0_bready(s_bready[0]), .axi_s0_arvalid(s_arvalid[0]), .axi_s0_araddr(s_araddr[0]),
    .axi_s0_arprot(3'd0), .axi_s0_arready(s_arready[0]), .axi_s0_rvalid(s_rvalid[0]),
    .axi_s0_rdata(s_rdata[0]), .axi_s0_rready(s_rready[0]),
    .axi_s1_awvalid(s_awvalid[1]), .axi_s1_awaddr(s_awaddr[1]), .axi_s1_awprot(3'd1),
    .axi_s1_awready(s_awready[1]), .axi_s1_wvalid(s_wvalid[1]), .axi_s1_wdata(s_wdata[1]),
    .axi_s1_wstrb(s_wstrb[1]), .axi_s1_wready(s_wready[1]), .axi_s1_bvalid(s_bvalid[1]),
    .axi_s1_bready(s_bready[1]), .axi_s1_arvalid(s_arvalid[1]), .axi_s1_araddr(s_araddr[1]),
    .axi_s1_arprot(3'd1), .axi_s1_arready(s_arready[1]), .axi_s1_rvalid(s_rvalid[1]),
    .axi_s1_rdata(s_rdata[1]), .axi_s1_rready(s_rready[1]),
    .axi_m_awvalid(m_awvalid), .axi_m_awaddr(m_awaddr), .axi_m_awprot(m_awprot),
    .axi_m_awready(aw_rdy), .axi_m_wvalid(m_wvalid), .axi_m_wdata(m_wdata),
    .axi_m_wstrb(m_wstrb), .axi_m_wready(w_rdy), .axi_m_bvalid(sl_bvalid),
    .axi_m_bready(m_bready), .axi_m_arvalid(m_arvalid), .axi_m_araddr(m_araddr),
    .axi_m_arprot(m_arprot), .axi_m_arready(ar_rdy), .axi_m_rvalid(sl_rvalid),
    .axi_m_rdata(sl_rdata), .axi_m_rready(m_rready), .wdt_err(wdt_err)
  );

  // Zero-wait slave model: response one cycle after the address/data handshakes.
  logic        aw_seen, w_seen;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  wire aw_hs = m_awvalid && aw_rdy;
  wire w_hs  = m_wvalid && w_rdy;
  wire ar_hs = m_arvalid && ar_rdy;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sl_bvalid <= 1'b0; sl_rvalid <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0;
      sl_rdata <= '0;
    end else begin
      if (aw_hs) cap_awaddr <= m_awaddr;
      if (w_hs) begin cap_wdata <= m_wdata; cap_wstrb <= m_wstrb; end
      if (sl_bvalid && m_bready) sl_bvalid <= 1'b0;
      if ((aw_seen || aw_hs) && (w_seen || w_hs)) begin
        sl_bvalid <= 1'b1; aw_seen <= 1'b0; w_seen <= 1'b0;
      end else begin
        if (aw_hs) aw_seen <= 1'b1;
        if (w_hs) w_seen <= 1'b1;
      end
      if (ar_hs) begin
        cap_araddr <= m_araddr; sl_rvalid <= 1'b1; sl_rdata <= rd_data;
      end else if (sl_rvalid && m_rready) begin
        sl_rvalid <= 1'b0;
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic do_read(input int m, input logic [31:0] addr, output int lat,
                         output logic [31:0] data, output logic other);
    int o = 1 - m;
    logic ar_pend = 1'b0;
    lat = -1; data = '0; other = 1'b0;
    s_araddr[m] = addr; s_arvalid[m] = 1'b1; s_rready[m] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (ar_pend) s_arvalid[m] = 1'b0;
      if (s_rvalid[o] || s_arready[o]) other = 1'b1;
      if (s_rvalid[m]) begin lat = c; data = s_rdata[m]; break; end
      ar_pend = s_arvalid[m] && s_arready[m];
    end
    s_arvalid[m] = 1'b0;
    @(posedge clk); #1;
    s_rready[m] = 1'b0;
  endtask

  task automatic do_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output int lat, output logic other);
    int o = 1 - m;
    logic aw_pend = 1'b0;
    logic w_pend = 1'b0;
    lat = -1; other = 1'b0;
    s_awaddr[m] = addr; s_wdata[m] = data; s_wstrb[m] = strb;
    s_awvalid[m] = 1'b1; s_wvalid[m] = 1'b1; s_bready[m] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (aw_pend) s_awvalid[m] = 1'b0;
      if (w_pend) s_wvalid[m] = 1'b0;
      if (s_bvalid[o] || s_awready[o] || s_wready[o]) other = 1'b1;
      if (s_bvalid[m]) begin lat = c; break; end
      aw_pend = s_awvalid[m] && s_awready[m];
      w_pend  = s_wvalid[m] && s_wready[m];
    end
    s_awvalid[m] = 1'b0; s_wvalid[m] = 1'b0;
    @(posedge clk); #1;
    s_bready[m] = 1'b0;
  endtask

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [31:0] data;
    int          exp_lat;
  } rd_vec_t;

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          exp_lat;
  } wr_vec_t;

  rd_vec_t rv[4];
  wr_vec_t wv[4];

  initial begin
    int          lat;
    logic [31:0] data;
    logic        other;
    int          ord[$];

    rv[0] = '{m: 0, addr: 32'h0000_0010, data: 32'h1234_5678, exp_lat: 2};
    rv[1] = '{m: 1, addr: 32'h0000_0020, data: 32'hA5A5_0F0F, exp_lat: 2};
    rv[2] = '{m: 0, addr: 32'h0000_0024, data: 32'hFFFF_FFFF, exp_lat: 2};
    rv[3] = '{m: 1, addr: 32'h0000_03FC, data: 32'h0000_0001, exp_lat: 2};
    wv[0] = '{m: 0, addr: 32'h0000_0100, data: 32'hCAFE_F00D, strb: 4'hF, exp_lat: 2};
    wv[1] = '{m: 1, addr: 32'h0000_0104, data: 32'h5555_AAAA, strb: 4'h3, exp_lat: 2};
    wv[2] = '{m: 1, addr: 32'h0000_0108, data: 32'h0102_0304, strb: 4'hC, exp_lat: 2};
    wv[3] = '{m: 0, addr: 32'h0000_010C, data: 32'h0000_0000, strb: 4'h1, exp_lat: 2};

    s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
    s_awaddr = '0; s_wdata = '0; s_araddr = '0; s_wstrb = '0;
    aw_rdy = 1'b1; w_rdy = 1'b1; ar_rdy = 1'b1; rd_data = '0;

    #12;
    chk("reset_outs", {s_awready, s_wready, s_bvalid, s_arready, s_rvalid,
                       m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, wdt_err}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      rd_data = rv[i].data;
      do_read(rv[i].m, rv[i].addr, lat, data, other);
      chk("rd_lat", lat, rv[i].exp_lat);
      chk("rd_data", data, rv[i].data);
      chk("rd_addr", cap_araddr, rv[i].addr);
      chk("rd_other_quiet", other, 0);
    end

    for (int i = 0; i < 4; i++) begin
      do_write(wv[i].m, wv[i].addr, wv[i].data, wv[i].strb, lat, other);
      chk("wr_lat", lat, wv[i].exp_lat);
      chk("wr_addr", cap_awaddr, wv[i].addr);
      chk("wr_data", cap_wdata, wv[i].data);
      chk("wr_strb", cap_wstrb, wv[i].strb);
      chk("wr_other_quiet", other, 0);
    end

    // Master 0 write and master 1 read run in parallel.
    rd_data = 32'h0BEE_F200;
    s_awaddr[0] = 32'h100; s_wdata[0] = 32'h1111_2222; s_wstrb[0] = 4'hF;
    s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; s_bready[0] = 1'b1;
    s_araddr[1] = 32'h200; s_arvalid[1] = 1'b1; s_rready[1] = 1'b1;
    @(posedge clk); #1;
    chk("par_aw_ar_together", {m_awvalid, m_arvalid}, 2'b11);
    chk("par_awaddr", m_awaddr, 32'h100);
    chk("par_araddr", m_araddr, 32'h200);
    @(posedge clk); #1;
    s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b0; s_arvalid[1] = 1'b0;
    chk("par_bvalid_s0", s_bvalid[0], 1);
    chk("par_rvalid_s1", s_rvalid[1], 1);
    chk("par_rdata_s1", s_rdata[1], 32'h0BEE_F200);
    @(posedge clk); #1;
    s_bready[0] = 1'b0; s_rready[1] = 1'b0;

    // wready three cycles ahead of awready.
    aw_rdy = 1'b0;
    s_awaddr[0] = 32'h140; s_wdata[0] = 32'hABCD_0123; s_wstrb[0] = 4'hF;
    s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; s_bready[0] = 1'b1;
    @(posedge clk); #1;
    chk("early_w_wready", s_wready[0], 1);
    @(posedge clk); #1;
    s_wvalid[0] = 1'b0;
    chk("early_w_wvalid_drop", m_wvalid, 0);
    chk("early_w_awvalid_held", m_awvalid, 1);
    chk("early_w_no_b_c2", s_bvalid[0], 0);
    @(posedge clk); #1;
    chk("early_w_no_b_c3", s_bvalid[0], 0);
    @(posedge clk); #1;
    chk("early_w_no_b_c4", s_bvalid[0], 0);
    aw_rdy = 1'b1;
    @(posedge clk); #1;
    s_awvalid[0] = 1'b0;
    chk("early_w_bvalid", s_bvalid[0], 1);
    chk("early_w_wdata", cap_wdata, 32'hABCD_0123);
    @(posedge clk); #1;
    chk("early_w_b_done", s_bvalid[0], 0);
    s_bready[0] = 1'b0;

    // Reset while a read response is pending.
    rd_data = 32'h7777_0000;
    s_araddr[0] = 32'h44; s_arvalid[0] = 1'b1; s_rready[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    s_arvalid[0] = 1'b0;
    chk("rst_pending_rvalid", s_rvalid[0], 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_abort_outs", {s_rvalid, s_arready, m_rready, m_arvalid}, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    rd_data = 32'h3030_3030;
    do_read(1, 32'h300, lat, data, other);
    chk("rst_after_lat", lat, 2);
    chk("rst_after_data", data, 32'h3030_3030);
    chk("rst_after_s0_quiet", other, 0);

    // Continuous requests from both masters alternate 0,1,0,1.
    s_araddr[0] = 32'h500; s_araddr[1] = 32'h600;
    s_arvalid = 2'b11; s_rready = 2'b11;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (s_rvalid[0]) ord.push_back(0);
      if (s_rvalid[1]) ord.push_back(1);
    end
    s_arvalid = 2'b00;
    @(posedge clk); #1;
    s_rready = 2'b00;
    chk("fair_count", ord.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("fair_order", (k < ord.size()) ? ord[k] : 99, k % 2);

`ifdef AXI4_ARB_WDT_EN
    begin
      logic early;
      early = 1'b0;
      ar_rdy = 1'b0;
      s_araddr[0] = 32'h700; s_arvalid[0] = 1'b1; s_rready[0] = 1'b0;
      for (int c = 1; c <= WDT; c++) begin
        @(posedge clk); #1;
        if (s_rvalid[0]) early = 1'b1;
      end
      chk("wdt_no_early_rvalid", early, 0);
      @(posedge clk); #1;
      chk("wdt_rvalid", s_rvalid[0], 1);
      chk("wdt_rdata", s_rdata[0], 32'hDEAD_BEEF);
      chk("wdt_slave_arvalid_drop", m_arvalid, 0);
      s_arvalid[0] = 1'b0;
      @(posedge clk); #1;
      chk("wdt_rvalid_held", s_rvalid[0], 1);
      chk("wdt_err_set", wdt_err, 1);
      s_rready[0] = 1'b1;
      @(posedge clk); #1;
      chk("wdt_rvalid_accepted", s_rvalid[0], 0);
      s_rready[0] = 1'b0;
      ar_rdy = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("wdt_err_sticky", wdt_err, 1);
    end
`else
    chk("wdt_err_tied_low", wdt_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
